// File: rtl/fft4_stream_if.sv
// rtl/fft4_stream_if.sv - sample/result handshake bundle for fft4_stream (mag_out present under FFT4_MAG_EN)
interface fft4_stream_if #(
    parameter int IN_W = 10
);
    localparam int OUT_W = IN_W + 3;

    logic                   new_t;
    logic [IN_W-1:0]        sample_in;
    logic                   flush;
    logic                   out_ack;
    logic [4*OUT_W-1:0]     re_out;
    logic [4*OUT_W-1:0]     im_out;
    logic                   done;
    logic                   busy;
    logic                   overrun;
`ifdef FFT4_MAG_EN
    logic [4*(OUT_W+1)-1:0] mag_out;

    modport master (
        output new_t, sample_in, flush, out_ack,
        input  re_out, im_out, done, busy, overrun, mag_out
    );

    modport slave (
        input  new_t, sample_in, flush, out_ack,
        output re_out, im_out, done, busy, overrun, mag_out
    );
`else
    modport master (
        output new_t, sample_in, flush, out_ack,
        input  re_out, im_out, done, busy, overrun
    );

    modport slave (
        input  new_t, sample_in, flush, out_ack,
        output re_out, im_out, done, busy, overrun
    );
`endif
endinterface

// File: rtl/fft4_stream.sv
// rtl/fft4_stream.sv - streaming 4-point real-input DFT, two butterfly stages, optional |re|+|im| via FFT4_MAG_EN
module fft4_stream #(
    parameter int IN_W      = 10,
    parameter int SIGNED_IN = 0,
    parameter int SHIFT     = 0
) (
    input  logic          clk_in,
    input  logic          reset,
    fft4_stream_if.slave  bus
);
    localparam int OUT_W = IN_W + 3;
    localparam int XW    = IN_W + 1;
    localparam int SW    = IN_W + 2;

    typedef enum logic [1:0] {LOAD, BF1, BF2, OUT} state_t;

    state_t                 state;
    state_t                 state_nx;
    logic                   busy_c;
    logic                   accept;
    logic [1:0]             idx;
    logic signed [XW-1:0]   x [4];
    logic signed [XW-1:0]   sample_ext;
    logic signed [SW-1:0]   s0, d0, s1, d1;
    logic signed [OUT_W-1:0] s0w, s1w, d0w, d1w;
    logic signed [OUT_W-1:0] bin_re [4];
    logic signed [OUT_W-1:0] bin_im [4];
    logic [4*OUT_W-1:0]     re_nx, im_nx;
    logic [4*OUT_W-1:0]     re_q, im_q;
    logic                   done_q;
    logic                   overrun_q;

    // a sample only lands in the frame while loading and not being flushed
    assign accept = (state == LOAD) && bus.new_t && !bus.flush;

    // widen the raw sample by one bit according to its signedness
    always_comb begin
        sample_ext = '0;
        if (SIGNED_IN != 0) begin
            sample_ext = {bus.sample_in[IN_W-1], bus.sample_in};
        end else begin
            sample_ext = {1'b0, bus.sample_in};
        end
    end

    // state register
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // next state and busy: load four samples, two butterfly edges, hold until acknowledged
    always_comb begin
        state_nx = state;
        busy_c   = 1'b1;
        case (state)
            LOAD: begin
                busy_c = 1'b0;
                if (accept && idx == 2'd3) begin
                    state_nx = BF1;
                end
            end
            BF1: state_nx = BF2;
            BF2: state_nx = OUT;
            OUT: begin
                if (bus.out_ack) begin
                    state_nx = LOAD;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    // sample buffer; idx wraps to 0 after the fourth sample, flush only rewinds idx
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            idx <= 2'd0;
            for (int n = 0; n < 4; n++) begin
                x[n] <= '0;
            end
        end else if (state == LOAD) begin
            if (bus.flush) begin
                idx <= 2'd0;
            end else if (bus.new_t) begin
                x[idx] <= sample_ext;
                idx    <= idx + 2'd1;
            end
        end
    end

    // first butterfly stage: even/odd pairs one half-period apart
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s0 <= '0;
            d0 <= '0;
            s1 <= '0;
            d1 <= '0;
        end else if (state == BF1) begin
            s0 <= {x[0][XW-1], x[0]} + {x[2][XW-1], x[2]};
            d0 <= {x[0][XW-1], x[0]} - {x[2][XW-1], x[2]};
            s1 <= {x[1][XW-1], x[1]} + {x[3][XW-1], x[3]};
            d1 <= {x[1][XW-1], x[1]} - {x[3][XW-1], x[3]};
        end
    end

    // second butterfly stage: combine with -j twiddle, then scale (floor)
    always_comb begin
        s0w = {s0[SW-1], s0};
        s1w = {s1[SW-1], s1};
        d0w = {d0[SW-1], d0};
        d1w = {d1[SW-1], d1};
        bin_re[0] = (s0w + s1w) >>> SHIFT;
        bin_im[0] = '0;
        bin_re[1] = d0w >>> SHIFT;
        bin_im[1] = (-d1w) >>> SHIFT;
        bin_re[2] = (s0w - s1w) >>> SHIFT;
        bin_im[2] = '0;
        bin_re[3] = d0w >>> SHIFT;
        bin_im[3] = d1w >>> SHIFT;
    end

    // pack bins little-endian: bin k at [k*OUT_W +: OUT_W]
    always_comb begin
        re_nx = '0;
        im_nx = '0;
        for (int k = 0; k < 4; k++) begin
            re_nx[k*OUT_W +: OUT_W] = bin_re[k];
            im_nx[k*OUT_W +: OUT_W] = bin_im[k];
        end
    end

    // result registers and done; bins stay put after done drops
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            re_q   <= '0;
            im_q   <= '0;
            done_q <= 1'b0;
        end else if (state == BF2) begin
            re_q   <= re_nx;
            im_q   <= im_nx;
            done_q <= 1'b1;
        end else if (state == OUT && bus.out_ack) begin
            done_q <= 1'b0;
        end
    end

    // sticky overrun: any strobe outside LOAD is lost
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (bus.new_t && state != LOAD) begin
            overrun_q <= 1'b1;
        end
    end

`ifdef FFT4_MAG_EN
    logic [4*(OUT_W+1)-1:0] mag_nx, mag_q;
    logic [OUT_W-1:0]       abs_re [4];
    logic [OUT_W-1:0]       abs_im [4];

    // |re|+|im| of the scaled bins; one extra bit absorbs the sum
    always_comb begin
        mag_nx = '0;
        for (int k = 0; k < 4; k++) begin
            abs_re[k] = bin_re[k][OUT_W-1] ? OUT_W'(-bin_re[k]) : OUT_W'(bin_re[k]);
            abs_im[k] = bin_im[k][OUT_W-1] ? OUT_W'(-bin_im[k]) : OUT_W'(bin_im[k]);
            mag_nx[k*(OUT_W+1) +: (OUT_W+1)] = {1'b0, abs_re[k]} + {1'b0, abs_im[k]};
        end
    end

    // magnitude registered alongside the bins
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            mag_q <= '0;
        end else if (state == BF2) begin
            mag_q <= mag_nx;
        end
    end

    assign bus.mag_out = mag_q;
`endif

    assign bus.re_out  = re_q;
    assign bus.im_out  = im_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_c;
    assign bus.overrun = overrun_q;

endmodule
